regfile_wr_arbiter: RTL

Shares the single register-file write port of the MIPS datapath between two writeback sources: ALU results (requester A) and memory loads (requester M). The block grants one source per cycle using round-robin priority and registers the winning write. It drives wr_addr into decoder5_32 and gates the decoder's one-hot outputs with wr_en. Writes to $zero are consumed but never reach the register file.

---
 rtl/regfile_wr_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wr_arbiter
//  Purpose  : Shares the single register-file write port between two
//             writeback sources, ALU results (A) and memory loads (M).
//             One source is granted per cycle with round-robin priority,
//             and the winning write is registered for one cycle.
//             wr_addr feeds decoder5_32, and wr_en gates its one-hot
//             outputs. Writes to $zero are accepted but never committed.
//  Optional : REGFILE_WR_BYPASS_EN adds decode-stage forwarding compares
//             (rs_addr/rt_addr in, fwd_rs/fwd_rt out).
//  Ports    :
//    clk, rst                   clock; asynchronous active-low reset
//    a_valid/a_addr/a_data      ALU writeback request
//    a_ready                    ALU request accepted this cycle
//    m_valid/m_addr/m_data      load writeback request
//    m_ready                    load request accepted this cycle
//    rf_stall                   register file busy, so no grants
//    wr_en/wr_addr/wr_data      registered write to the register file
//    wr_src                     0 = ALU, 1 = MEM for the current write
//    zero_drop                  pulse: accepted $zero write discarded
//    wr_count                   saturating count of committed writes
//    rs_addr/rt_addr, fwd_rs/fwd_rt   (REGFILE_WR_BYPASS_EN only)
//  Revision : 1.0  initial release
// ============================================================================
module regfile_wr_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              m_valid,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_data,
  output logic              m_ready,
  input  logic              rf_stall,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_src,
  output logic              zero_drop,
`ifdef REGFILE_WR_BYPASS_EN
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              fwd_rs,
  output logic              fwd_rt,
`endif
  output logic [CNT_W-1:0]  wr_count
);

  // Priority state: which requester wins the next contested cycle.
  typedef enum logic [0:0] {
    PRI_M = 1'b0,
    PRI_A = 1'b1
  } pri_state_t;

  pri_state_t r_state;
  pri_state_t w_state_next;

  logic              w_grant_a;
  logic              w_grant_m;
  logic              w_take;
  logic              w_contested;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_sel_zero;
  logic              w_commit;
  logic              w_cnt_sat;

  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_wr_src;
  logic              r_zero_drop;
  logic [CNT_W-1:0]  r_count;

  // --------------------------------------------------------------------------
  // Priority state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= PRI_M;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Grant and next-state logic
  // A stall masks everything. This includes the state update, so a cycle
  // that would have been contested but was stalled leaves priority alone.
  // --------------------------------------------------------------------------
  always_comb begin
    w_grant_a    = 1'b0;
    w_grant_m    = 1'b0;
    w_contested  = 1'b0;
    w_state_next = r_state;

    if (!rf_stall) begin
      w_contested = a_valid && m_valid;
      if (w_contested) begin
        w_grant_a = (r_state == PRI_A);
        w_grant_m = (r_state == PRI_M);
        // The winner loses favour for the next contested cycle.
        w_state_next = w_grant_a ? PRI_M : PRI_A;
      end else begin
        w_grant_a = a_valid;
        w_grant_m = m_valid;
      end
    end
  end

  assign a_ready = w_grant_a;
  assign m_ready = w_grant_m;

  // --------------------------------------------------------------------------
  // Winning request select
  // A grant implies valid, so w_take marks a completed handshake.
  // --------------------------------------------------------------------------
  assign w_take     = w_grant_a || w_grant_m;
  assign w_sel_addr = w_grant_m ? m_addr : a_addr;
  assign w_sel_data = w_grant_m ? m_data : a_data;
  assign w_sel_zero = (w_sel_addr == '0);
  assign w_commit   = w_take && !w_sel_zero;
  assign w_cnt_sat  = &r_count;

  // --------------------------------------------------------------------------
  // Registered write stage
  // Address, data and source update only on a real commit, so they hold
  // their values through idle cycles and discarded $zero writes.
  // The counter advances on the same edge that raises wr_en. As a result,
  // wr_count already includes the write currently being presented.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_wr_src    <= 1'b0;
      r_zero_drop <= 1'b0;
      r_count     <= '0;
    end else begin
      r_wr_en     <= w_commit;
      r_zero_drop <= w_take && w_sel_zero;
      if (w_commit) begin
        r_wr_addr <= w_sel_addr;
        r_wr_data <= w_sel_data;
        r_wr_src  <= w_grant_m;
      end
      if (w_commit && !w_cnt_sat) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign wr_src    = r_wr_src;
  assign zero_drop = r_zero_drop;
  assign wr_count  = r_count;

`ifdef REGFILE_WR_BYPASS_EN
  // --------------------------------------------------------------------------
  // Decode-stage forwarding compares against the registered write.
  // $zero never forwards, even though wr_en cannot be high for it.
  // --------------------------------------------------------------------------
  assign fwd_rs = r_wr_en && (r_wr_addr == rs_addr) && (rs_addr != '0);
  assign fwd_rt = r_wr_en && (r_wr_addr == rt_addr) && (rt_addr != '0);
`endif

endmodule
`default_nettype wire
